pc_branch_sequencer: RTL

Consumer end of the branch-decision interface. Owns the program counter and applies MIPS delayed-branch semantics. It takes the taken/not-taken decision (condition_met) and the jump controls for the instruction at the current PC, and computes the target. It redirects fetch only after the delay-slot instruction, and halts the CPU when control transfers to the halt address.

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/branch_target_calc.sv | 35 +++
 rtl/pc_branch_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default addresses for the PC / delayed-branch sequencer.
// Used by the RTL and by memory/testbench code that needs the boot and halt addresses.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    JK_NONE  = 2'b00,
    JK_INDEX = 2'b01,
    JK_REG   = 2'b10
  } jump_kind_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DELAY  = 2'b01,
    HALTED = 2'b10
  } state_e;

  // RK_BRANCH means no jump: the target is the PC-relative branch target,
  // which only redirects when the condition is met.
  typedef enum logic [1:0] {
    RK_BRANCH = 2'b00,
    RK_INDEX  = 2'b01,
    RK_REG    = 2'b10
  } redirect_kind_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target selection for the instruction at the current PC.
// Jumps take priority over the PC-relative branch target; the reserved jump kind acts as none.
module branch_target_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_index,
  input  logic [31:0] jump_reg,
  input  logic [1:0]  jump_kind,
  output logic [31:0] target,
  output logic [1:0]  redirect_kind
);

  logic [31:0] branch_tgt;

  assign branch_tgt = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target        = branch_tgt;
    redirect_kind = RK_BRANCH;
    case (jump_kind)
      JK_INDEX: begin
        target        = {pc_plus4[31:28], jump_index, 2'b00};
        redirect_kind = RK_INDEX;
      end
      JK_REG: begin
        target        = jump_reg;
        redirect_kind = RK_REG;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_branch_sequencer.sv
// Program counter with MIPS delayed-branch semantics: a redirect is latched when the
// branch retires and applied after the delay slot retires; transfer to HALT_ADDR halts.
module pc_branch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        condition_met,
  input  logic [1:0]  jump_kind,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_index,
  input  logic [31:0] jump_reg,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_misaligned
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [1:0]  redirect_kind;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;

  branch_target_calc u_target (
    .pc_plus4      (pc_plus4),
    .imm16         (imm16),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jump_kind     (jump_kind),
    .target        (target),
    .redirect_kind (redirect_kind)
  );

  assign redirect = (redirect_kind != RK_BRANCH) || condition_met;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    misaligned_d = misaligned_q;
    if (advance) begin
      case (state_q)
        RUN: begin
          pc_d = pc_plus4;
          if (redirect) begin
            pending_d    = {target[31:2], 2'b00};
            misaligned_d = misaligned_q | (target[1:0] != 2'b00);
            state_d      = DELAY;
          end
        end
        // Branch controls presented in the delay slot are deliberately ignored.
        DELAY: begin
          pc_d    = pending_q;
          state_d = (pending_q == HALT_ADDR) ? HALTED : RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      pending_q    <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc              = pc_q;
  assign link_addr       = pc_q + 32'd8;
  assign in_delay_slot   = (state_q == DELAY);
  assign active          = (state_q != HALTED);
  assign addr_misaligned = misaligned_q;

endmodule
